// File: rtl/bmp_stream_if.sv
// Byte-stream handshake carrying a BMP file into the reader.
// The source drives valid/data; the reader returns ready.
interface bmp_stream_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/bmp_stream_reader.sv
// Parses an 8-bit grayscale BMP byte stream: header bytes go to the
// header buffer, pixel bytes to the image RAM, row padding is dropped.
module bmp_stream_reader #(
  parameter int ROW     = 100,
  parameter int COLUMN  = 100,
  parameter int HDR_MAX = 1078,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  bmp_stream_if.slave       s,
  output logic              hdr_we,
  output logic [ADDR_W-1:0] hdr_addr,
  output logic [7:0]        hdr_data,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              busy,
  output logic              header_done,
  output logic              image_done,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam int PIX_N = ROW * COLUMN;
  localparam int PAD_B = (4 - COLUMN % 4) % 4;
  localparam int COL_W = $clog2(COLUMN + 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, PIXEL, PAD, DONE, ERROR
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
  logic [1:0]        pad_cnt_q, pad_cnt_d;
  logic [31:0]       offset_q, offset_d;
  logic [31:0]       width_q, width_d;
  logic [31:0]       height_q, height_d;
  logic [15:0]       bpp_q, bpp_d;

  logic              hdr_we_q, hdr_we_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [7:0]        hdr_data_q, hdr_data_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic              hdr_done_q, hdr_done_d;
  logic              img_done_q, img_done_d;
  logic              error_q, error_d;
  logic [2:0]        err_code_q, err_code_d;

  logic        run;
  logic        acc;
  logic        lo;
  logic [4:0]  fld;
  logic [15:0] bpp_full;
  logic [2:0]  ec;

  assign run = (state_q == HEADER) ||
               (state_q == PIXEL)  ||
               (state_q == PAD);
  assign acc = s.s_valid & run;
  // header fields of interest all sit below byte 32
  assign lo  = (byte_cnt_q < ADDR_W'(32));
  assign fld = byte_cnt_q[4:0];
  assign bpp_full = {s.s_data, bpp_q[7:0]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    col_cnt_d  = col_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    offset_d   = offset_q;
    width_d    = width_q;
    height_d   = height_q;
    bpp_d      = bpp_q;
    hdr_we_d   = 1'b0;
    hdr_addr_d = hdr_addr_q;
    hdr_data_d = hdr_data_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    hdr_done_d = hdr_done_q;
    img_done_d = img_done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    ec         = 3'd0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = HEADER;
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          col_cnt_d  = '0;
          pad_cnt_d  = '0;
          offset_d   = '0;
          width_d    = '0;
          height_d   = '0;
          bpp_d      = '0;
          hdr_done_d = 1'b0;
          img_done_d = 1'b0;
          error_d    = 1'b0;
          err_code_d = 3'd0;
        end
      end

      HEADER: begin
        if (acc) begin
          hdr_we_d   = 1'b1;
          hdr_addr_d = byte_cnt_q;
          hdr_data_d = s.s_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (lo) begin
            case (fld)
              5'd10: offset_d[7:0]   = s.s_data;
              5'd11: offset_d[15:8]  = s.s_data;
              5'd12: offset_d[23:16] = s.s_data;
              5'd13: offset_d[31:24] = s.s_data;
              5'd18: width_d[7:0]    = s.s_data;
              5'd19: width_d[15:8]   = s.s_data;
              5'd20: width_d[23:16]  = s.s_data;
              5'd21: width_d[31:24]  = s.s_data;
              5'd22: height_d[7:0]   = s.s_data;
              5'd23: height_d[15:8]  = s.s_data;
              5'd24: height_d[23:16] = s.s_data;
              5'd25: height_d[31:24] = s.s_data;
              5'd28: bpp_d[7:0]      = s.s_data;
              5'd29: bpp_d[15:8]     = s.s_data;
              default: ;
            endcase
            if (fld == 5'd0 && s.s_data != 8'h42)
              ec = 3'd1;
            if (fld == 5'd1 && s.s_data != 8'h4D)
              ec = 3'd1;
            if (fld == 5'd29) begin
              if (bpp_full != 16'd8)
                ec = 3'd2;
              else if (width_q != 32'(COLUMN) ||
                       height_q != 32'(ROW))
                ec = 3'd3;
              else if (offset_q < 32'd54 ||
                       offset_q > 32'(HDR_MAX))
                ec = 3'd4;
            end
          end
          if (ec != 3'd0) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = ec;
          end else if (!lo &&
                       32'(byte_cnt_q) + 32'd1 == offset_q) begin
            state_d    = PIXEL;
            hdr_done_d = 1'b1;
          end
        end
      end

      PIXEL: begin
        if (acc) begin
          pix_we_d   = 1'b1;
          pix_addr_d = pix_cnt_q;
          pix_data_d = s.s_data;
          pix_cnt_d  = pix_cnt_q + 1'b1;
          col_cnt_d  = col_cnt_q + 1'b1;
          if (pix_cnt_q == ADDR_W'(PIX_N - 1)) begin
            state_d    = DONE;
            img_done_d = 1'b1;
          end else if (col_cnt_q == COL_W'(COLUMN - 1)) begin
            col_cnt_d = '0;
            pad_cnt_d = '0;
            if (PAD_B != 0)
              state_d = PAD;
          end
        end
      end

      PAD: begin
        if (acc) begin
          pad_cnt_d = pad_cnt_q + 1'b1;
          if (pad_cnt_q == 2'(PAD_B - 1))
            state_d = PIXEL;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      pix_cnt_q  <= '0;
      col_cnt_q  <= '0;
      pad_cnt_q  <= '0;
      offset_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      bpp_q      <= '0;
      hdr_we_q   <= 1'b0;
      hdr_addr_q <= '0;
      hdr_data_q <= '0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
      hdr_done_q <= 1'b0;
      img_done_q <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      col_cnt_q  <= col_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      offset_q   <= offset_d;
      width_q    <= width_d;
      height_q   <= height_d;
      bpp_q      <= bpp_d;
      hdr_we_q   <= hdr_we_d;
      hdr_addr_q <= hdr_addr_d;
      hdr_data_q <= hdr_data_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      hdr_done_q <= hdr_done_d;
      img_done_q <= img_done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign s.s_ready   = run;
  assign busy        = run;
  assign hdr_we      = hdr_we_q;
  assign hdr_addr    = hdr_addr_q;
  assign hdr_data    = hdr_data_q;
  assign pix_we      = pix_we_q;
  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign header_done = hdr_done_q;
  assign image_done  = img_done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_bmp_stream_reader.sv
// Scoreboard bench: a 100x100 reader and a padded 98x2 reader.
// Stimulus queues expected writes; a negedge monitor pops and compares.
module tb_bmp_stream_reader;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
    logic        l;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  bmp_stream_if ifa ();
  bmp_stream_if ifb ();

  logic        hwe_a, pwe_a, hdn_a, idn_a, bsy_a, err_a;
  logic [13:0] ha_a, pa_a;
  logic [7:0]  hd_a, pd_a;
  logic [2:0]  ec_a;
  logic        hwe_b, pwe_b, hdn_b, idn_b, bsy_b, err_b;
  logic [13:0] ha_b, pa_b;
  logic [7:0]  hd_b, pd_b;
  logic [2:0]  ec_b;

  bmp_stream_reader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s(ifa.slave),
    .hdr_we(hwe_a), .hdr_addr(ha_a), .hdr_data(hd_a),
    .pix_we(pwe_a), .pix_addr(pa_a), .pix_data(pd_a),
    .busy(bsy_a), .header_done(hdn_a), .image_done(idn_a),
    .error(err_a), .err_code(ec_a)
  );

  bmp_stream_reader #(.ROW(2), .COLUMN(98)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s(ifb.slave),
    .hdr_we(hwe_b), .hdr_addr(ha_b), .hdr_data(hd_b),
    .pix_we(pwe_b), .pix_addr(pa_b), .pix_data(pd_b),
    .busy(bsy_b), .header_done(hdn_b), .image_done(idn_b),
    .error(err_b), .err_code(ec_b)
  );

  always #5 clk = ~clk;

  ent_t hq[2][$];
  ent_t pq[2][$];
  int   errs = 0;
  int   chks = 0;
  bit   stall = 0;
  logic [7:0] hb [0:1077];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int s, input logic hw,
                     input logic [13:0] ha, input logic [7:0] hd,
                     input logic hdn, input logic pw,
                     input logic [13:0] pa, input logic [7:0] pd,
                     input logic idn);
    ent_t e;
    if (hw) begin
      if (hq[s].size() == 0) begin
        chk($sformatf("hdr_unexp%0d", s), {18'd0, ha}, 32'hFFFF);
      end else begin
        e = hq[s].pop_front();
        chk($sformatf("hdr_addr%0d", s), 32'(ha), 32'(e.a));
        chk($sformatf("hdr_data%0d", s), 32'(hd), 32'(e.d));
        chk($sformatf("header_done%0d", s), 32'(hdn), 32'(e.l));
      end
    end
    if (pw) begin
      if (pq[s].size() == 0) begin
        chk($sformatf("pix_unexp%0d", s), {18'd0, pa}, 32'hFFFF);
      end else begin
        e = pq[s].pop_front();
        chk($sformatf("pix_addr%0d", s), 32'(pa), 32'(e.a));
        chk($sformatf("pix_data%0d", s), 32'(pd), 32'(e.d));
        chk($sformatf("image_done%0d", s), 32'(idn), 32'(e.l));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, hwe_a, ha_a, hd_a, hdn_a, pwe_a, pa_a, pd_a, idn_a);
    mon(1, hwe_b, ha_b, hd_b, hdn_b, pwe_b, pa_b, pd_b, idn_b);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic setv(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin
      ifa.s_valid = v;
      ifa.s_data  = d;
    end else begin
      ifb.s_valid = v;
      ifb.s_data  = d;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? ifa.s_ready : ifb.s_ready;
  endfunction

  // called and returns at a negedge; the byte is accepted in between
  task automatic drv(input int s, input logic [7:0] b);
    int n = 0;
    if (stall) begin
      while ($urandom_range(99) < 40) begin
        setv(s, 1'b0, 8'h00);
        @(negedge clk);
      end
    end
    setv(s, 1'b1, b);
    while (!rdy(s) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(rdy(s)), 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse(input int s);
    setv(s, 1'b0, 8'h00);
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic mk_hdr(input logic [31:0] off, input logic [31:0] w,
                        input logic [31:0] h, input logic [15:0] bpp,
                        input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 1078; i++) hb[i] = 8'(i * 7 + 3);
    hb[0] = b0;
    hb[1] = b1;
    for (int k = 0; k < 4; k++) begin
      hb[10 + k] = off[8*k +: 8];
      hb[18 + k] = w[8*k +: 8];
      hb[22 + k] = h[8*k +: 8];
    end
    hb[28] = bpp[7:0];
    hb[29] = bpp[15:8];
  endtask

  task automatic send_hdr(input int s, input int n, input bit fin);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.a = 14'(i);
      e.d = hb[i];
      e.l = fin && (i == n - 1);
      hq[s].push_back(e);
      drv(s, hb[i]);
    end
  endtask

  function automatic logic [7:0] pv(input int p);
    return 8'(p * 31 + p / 97 + 5);
  endfunction

  task automatic send_pix(input int s, input int cols, input int rows,
                          input int npix);
    ent_t e;
    int padb = (4 - cols % 4) % 4;
    for (int p = 0; p < npix; p++) begin
      e.a = 14'(p);
      e.d = pv(p);
      e.l = (p == cols * rows - 1);
      pq[s].push_back(e);
      drv(s, pv(p));
      if ((p + 1) % cols == 0 && p != cols * rows - 1)
        for (int k = 0; k < padb; k++) drv(s, 8'hEE);
    end
  endtask

  task automatic check_end(input int s, input string nm,
                           input logic er, input logic [2:0] ec,
                           input logic idn, input logic hdn);
    setv(s, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_hq_left"}, 32'(hq[s].size()), 32'd0);
    chk({nm, "_pq_left"}, 32'(pq[s].size()), 32'd0);
    if (s == 0) begin
      chk({nm, "_status"}, {26'd0, err_a, ec_a, idn_a, hdn_a},
          {26'd0, er, ec, idn, hdn});
      chk({nm, "_ready_busy"}, {30'd0, ifa.s_ready, bsy_a}, 32'd0);
    end else begin
      chk({nm, "_status"}, {26'd0, err_b, ec_b, idn_b, hdn_b},
          {26'd0, er, ec, idn, hdn});
      chk({nm, "_ready_busy"}, {30'd0, ifb.s_ready, bsy_b}, 32'd0);
    end
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_hdr"}, {9'd0, hwe_a, ha_a, hd_a}, 32'd0);
    chk({nm, "_pix"}, {9'd0, pwe_a, pa_a, pd_a}, 32'd0);
    chk({nm, "_flags"}, {24'd0, ifa.s_ready, bsy_a, hdn_a, idn_a,
                         err_a, ec_a}, 32'd0);
  endtask

  task automatic err_case(input string nm, input int n,
                          input logic [2:0] ec);
    pulse(0);
    send_hdr(0, n, 1'b0);
    check_end(0, nm, 1'b1, ec, 1'b0, 1'b0);
  endtask

  initial begin
    setv(0, 1'b0, 8'h00);
    setv(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst = 1'b0;
    @(negedge clk);

    // full 100x100 file, continuous stream
    mk_hdr(32'd1078, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    pulse(0);
    send_hdr(0, 1078, 1'b1);
    send_pix(0, 100, 100, 10000);
    check_end(0, "full", 1'b0, 3'd0, 1'b1, 1'b1);

    // header validation errors
    mk_hdr(32'd1078, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4E);
    err_case("sig_b1", 2, 3'd1);
    mk_hdr(32'd1078, 32'd100, 32'd100, 16'd8, 8'h43, 8'h4D);
    err_case("sig_b0", 1, 3'd1);
    mk_hdr(32'd1078, 32'd100, 32'd100, 16'd24, 8'h42, 8'h4D);
    err_case("bpp24", 30, 3'd2);
    mk_hdr(32'd1078, 32'd99, 32'd100, 16'd24, 8'h42, 8'h4D);
    err_case("bpp_over_size", 30, 3'd2);
    mk_hdr(32'd1078, 32'd99, 32'd100, 16'd8, 8'h42, 8'h4D);
    err_case("width99", 30, 3'd3);
    mk_hdr(32'd1078, 32'd100, 32'hFFFF_FF9C, 16'd8, 8'h42, 8'h4D);
    err_case("topdown", 30, 3'd3);
    mk_hdr(32'd2000, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    err_case("off2000", 30, 3'd4);
    mk_hdr(32'd53, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    err_case("off53", 30, 3'd4);
    mk_hdr(32'd1079, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    err_case("off1079", 30, 3'd4);

    // smallest legal offset, then stalled stream with ignored start
    mk_hdr(32'd54, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    pulse(0);
    send_hdr(0, 54, 1'b1);
    stall = 1;
    pulse(0);
    send_pix(0, 100, 100, 10000);
    check_end(0, "off54_stall", 1'b0, 3'd0, 1'b1, 1'b1);

    // padded 98x2 build
    mk_hdr(32'd1078, 32'd98, 32'd2, 16'd8, 8'h42, 8'h4D);
    pulse(1);
    send_hdr(1, 1078, 1'b1);
    send_pix(1, 98, 2, 196);
    check_end(1, "pad98", 1'b0, 3'd0, 1'b1, 1'b1);
    stall = 0;

    // reset mid-image, then a clean full file
    mk_hdr(32'd1078, 32'd100, 32'd100, 16'd8, 8'h42, 8'h4D);
    pulse(0);
    send_hdr(0, 1078, 1'b1);
    send_pix(0, 100, 100, 5000);
    setv(0, 1'b0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst_chk("midrst");
    chk("midrst_pq_left", 32'(pq[0].size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(0);
    send_hdr(0, 1078, 1'b1);
    send_pix(0, 100, 100, 10000);
    check_end(0, "after_rst", 1'b0, 3'd0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
